operands_arbiter: RTL and testbench

- Merges the scalar and vector operand-collector streams of one issue slice into the single operands stream feeding the dispatch stage.
- Scalar packets are single-beat. Vector packets are multi-beat, delimited by eop, and must reach dispatch contiguous and unbroken.
- Arbitration is weighted round-robin with a scalar starvation guard. Output is registered through a 2-entry elastic buffer, which gives full throughput and no combinational path from out_ready to the input ready signals.

---
 rtl/operands_arbiter_pkg.sv | 19 +
 rtl/operands_arbiter_if.sv | 27 ++
 rtl/operands_elastic_buf.sv | 48 ++++
 rtl/operands_arbiter.sv | 112 +++++++++++
 tb/tb_operands_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operands_arbiter_pkg.sv
// rtl/operands_arbiter_pkg.sv - shared types for the scalar/vector operands arbiter
package operands_arbiter_pkg;

  typedef enum logic {
    OPSRC_SCALAR = 1'b0,
    OPSRC_VECTOR = 1'b1
  } opsrc_e;

  typedef enum logic {
    ARB    = 1'b0,
    LOCK_V = 1'b1
  } arb_state_e;

  // Vector wins a tie when it is its turn or its weighted run is still open.
  function automatic logic vector_turn(input opsrc_e last_grant, input logic run_open);
    return (last_grant == OPSRC_SCALAR) || run_open;
  endfunction

endpackage

// File: rtl/operands_arbiter_if.sv
// rtl/operands_arbiter_if.sv - operand input streams and dispatch output stream
interface operands_arbiter_if #(
  parameter int DATAW = 256
);
  logic             sc_valid;
  logic [DATAW-1:0] sc_data;
  logic             sc_ready;
  logic             vc_valid;
  logic [DATAW-1:0] vc_data;
  logic             vc_eop;
  logic             vc_ready;
  logic             out_valid;
  logic [DATAW-1:0] out_data;
  logic             out_src;
  logic             out_eop;
  logic             out_ready;

  modport master (
    output sc_valid, sc_data, vc_valid, vc_data, vc_eop, out_ready,
    input  sc_ready, vc_ready, out_valid, out_data, out_src, out_eop
  );

  modport slave (
    input  sc_valid, sc_data, vc_valid, vc_data, vc_eop, out_ready,
    output sc_ready, vc_ready, out_valid, out_data, out_src, out_eop
  );
endinterface

// File: rtl/operands_elastic_buf.sv
// rtl/operands_elastic_buf.sv - 2-entry elastic FIFO between arbitration and dispatch
module operands_elastic_buf #(
  parameter int WIDTH = 258
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // No pop-through: a full buffer refuses a push even when popping.
  assign push_ok = push && (count != 2'd2);
  assign pop_ok  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/operands_arbiter.sv
// rtl/operands_arbiter.sv - weighted round-robin merge of scalar and vector operand streams
module operands_arbiter
  import operands_arbiter_pkg::*;
#(
  parameter int DATAW        = 256,
  parameter int VEC_WEIGHT   = 2,
  parameter int STARVE_LIMIT = 16,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  operands_arbiter_if.slave bus,
  output logic [PERF_W-1:0] perf_conflicts,
  output logic [PERF_W-1:0] perf_stalls
);

  localparam int RUN_W = $clog2(VEC_WEIGHT + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VEC_WEIGHT);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);
  localparam int BW = DATAW + 2;

  arb_state_e       state;
  opsrc_e           last_grant;
  logic [RUN_W-1:0] vec_run;
  logic [STV_W-1:0] starve_cnt;
  logic [1:0]       count;
  logic             full;
  logic             grant_sc;
  logic             grant_vc;
  logic             sc_acc;
  logic             vc_acc;
  logic             run_open;
  logic             conflict;
  logic             stall;
  logic [BW-1:0]    push_data;
  logic [BW-1:0]    head;

  assign full = (count == 2'd2);
  // vec_run == 0 with last_grant == vector only exists out of reset; that tie goes to scalar.
  assign run_open = (vec_run != '0) && (vec_run < RUN_MAX);

  always_comb begin
    grant_sc = 1'b0;
    grant_vc = 1'b0;
    if (state == LOCK_V) begin
      grant_vc = 1'b1;
    end else if (bus.sc_valid && bus.vc_valid) begin
      if (starve_cnt >= STV_MAX)                  grant_sc = 1'b1;
      else if (vector_turn(last_grant, run_open)) grant_vc = 1'b1;
      else                                        grant_sc = 1'b1;
    end else begin
      grant_sc = bus.sc_valid;
      grant_vc = bus.vc_valid;
    end
  end

  assign bus.sc_ready = grant_sc && !full;
  assign bus.vc_ready = grant_vc && !full;
  assign sc_acc       = bus.sc_valid && bus.sc_ready;
  assign vc_acc       = bus.vc_valid && bus.vc_ready;
  assign conflict     = bus.sc_valid && bus.vc_valid;
  assign stall        = full && ((grant_sc && bus.sc_valid) || (grant_vc && bus.vc_valid));
  assign push_data    = sc_acc ? {bus.sc_data, 1'(OPSRC_SCALAR), 1'b1}
                               : {bus.vc_data, 1'(OPSRC_VECTOR), bus.vc_eop};

  operands_elastic_buf #(.WIDTH(BW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (sc_acc || vc_acc),
    .push_data (push_data),
    .pop       (bus.out_valid && bus.out_ready),
    .head      (head),
    .count     (count)
  );

  assign bus.out_valid = (count != 2'd0);
  assign {bus.out_data, bus.out_src, bus.out_eop} = head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ARB;
      last_grant     <= OPSRC_VECTOR;
      vec_run        <= '0;
      starve_cnt     <= '0;
      perf_conflicts <= '0;
      perf_stalls    <= '0;
    end else begin
      case (state)
        ARB:    if (vc_acc && !bus.vc_eop) state <= LOCK_V;
        LOCK_V: if (vc_acc && bus.vc_eop)  state <= ARB;
      endcase

      if (sc_acc) begin
        last_grant <= OPSRC_SCALAR;
        vec_run    <= '0;
        starve_cnt <= '0;
      end else if (bus.sc_valid && !bus.sc_ready && starve_cnt != STV_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (vc_acc && bus.vc_eop) begin
        last_grant <= OPSRC_VECTOR;
        if (vec_run != RUN_MAX) vec_run <= vec_run + 1'b1;
      end

      perf_conflicts <= perf_conflicts + PERF_W'(conflict);
      perf_stalls    <= perf_stalls + PERF_W'(stall);
    end
  end

endmodule

// File: tb/tb_operands_arbiter.sv
// tb/tb_operands_arbiter.sv - self-checking bench for operands_arbiter
module tb_operands_arbiter;
  localparam int DW = 64;
  localparam int VW = 2;
  localparam int SL = 16;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] perf_conflicts;
  logic [PW-1:0] perf_stalls;

  operands_arbiter_if #(.DATAW(DW)) bus ();

  operands_arbiter #(.DATAW(DW), .VEC_WEIGHT(VW), .STARVE_LIMIT(SL), .PERF_W(PW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .perf_conflicts (perf_conflicts),
    .perf_stalls    (perf_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          src;
    logic          eop;
  } beat_t;

  typedef struct {
    logic sv, vv, eop, ordy;
    logic scr, vcr, ov, src;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: buffered beats in acceptance order plus arbitration history.
  beat_t         q[$];
  logic          popped[$];
  logic          m_locked;
  logic          m_last_vec;
  int            m_run;
  int            m_starve;
  logic [PW-1:0] m_conf;
  logic [PW-1:0] m_stall;

  logic          obs_scr, obs_vcr, obs_ov, obs_src;
  logic [PW-1:0] obs_conf, obs_stall;
  logic [DW-1:0] seq = '0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_clear();
    q.delete();
    m_locked   = 1'b0;
    m_last_vec = 1'b1;
    m_run      = 0;
    m_starve   = 0;
    m_conf     = '0;
    m_stall    = '0;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.sc_valid  = 1'b0;
    bus.vc_valid  = 1'b0;
    bus.vc_eop    = 1'b0;
    bus.out_ready = 1'b0;
    bus.sc_data   = '0;
    bus.vc_data   = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chkw("rst_out_data", bus.out_data, 64'd0);
    chk1("rst_out_src", bus.out_src, 1'b0);
    chk1("rst_out_eop", bus.out_eop, 1'b0);
    chkw("rst_perf_conflicts", 64'(perf_conflicts), 64'd0);
    chkw("rst_perf_stalls", 64'(perf_stalls), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic sv, input logic vv, input logic eop, input logic ordy,
                       input logic [DW-1:0] sd, input logic [DW-1:0] vd);
    logic  full, g_sc, g_vc, e_scr, e_vcr, e_ov, acc_sc, acc_vc;
    beat_t b;
    bus.sc_valid  = sv;
    bus.vc_valid  = vv;
    bus.vc_eop    = eop;
    bus.out_ready = ordy;
    bus.sc_data   = sd;
    bus.vc_data   = vd;
    #2;
    full = (q.size() == 2);
    g_sc = 1'b0;
    g_vc = 1'b0;
    if (m_locked) g_vc = 1'b1;
    else if (sv && vv) begin
      if (m_starve >= SL)                                 g_sc = 1'b1;
      else if (!m_last_vec || (m_run > 0 && m_run < VW))  g_vc = 1'b1;
      else                                                g_sc = 1'b1;
    end else begin
      g_sc = sv;
      g_vc = vv;
    end
    e_scr = g_sc && !full;
    e_vcr = g_vc && !full;
    e_ov  = (q.size() != 0);

    obs_scr   = bus.sc_ready;
    obs_vcr   = bus.vc_ready;
    obs_ov    = bus.out_valid;
    obs_src   = bus.out_src;
    obs_conf  = perf_conflicts;
    obs_stall = perf_stalls;

    chk1("sc_ready", bus.sc_ready, e_scr);
    chk1("vc_ready", bus.vc_ready, e_vcr);
    chk1("out_valid", bus.out_valid, e_ov);
    if (e_ov) begin
      chkw("out_data", bus.out_data, q[0].data);
      chk1("out_src", bus.out_src, q[0].src);
      chk1("out_eop", bus.out_eop, q[0].eop);
    end
    chkw("perf_conflicts", 64'(perf_conflicts), 64'(m_conf));
    chkw("perf_stalls", 64'(perf_stalls), 64'(m_stall));

    acc_sc = sv && e_scr;
    acc_vc = vv && e_vcr;
    if (sv && vv) m_conf = m_conf + 1'b1;
    if (full && (m_locked ? vv : (sv || vv))) m_stall = m_stall + 1'b1;
    if (e_ov && ordy) begin
      popped.push_back(q[0].src);
      void'(q.pop_front());
    end
    if (acc_sc) begin
      b.data = sd; b.src = 1'b0; b.eop = 1'b1;
      q.push_back(b);
      m_starve   = 0;
      m_run      = 0;
      m_last_vec = 1'b0;
    end else if (sv && !e_scr && m_starve < SL) begin
      m_starve++;
    end
    if (acc_vc) begin
      b.data = vd; b.src = 1'b1; b.eop = eop;
      q.push_back(b);
      m_locked = !eop;
      if (eop) begin
        m_last_vec = 1'b1;
        if (m_run < VW) m_run++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t          tbl[15];
  logic [PW-1:0] saved;

  initial begin
    // sv vv eop ordy | sc_ready vc_ready out_valid out_src
    tbl[0]  = '{1, 1, 1, 1, 1, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 1, 0, 1, 1, 0};
    tbl[2]  = '{1, 1, 1, 1, 0, 1, 1, 1};
    tbl[3]  = '{1, 1, 1, 1, 1, 0, 1, 1};
    tbl[4]  = '{1, 1, 1, 1, 0, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 1, 0, 0, 1, 1};
    tbl[6]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 0, 0, 1, 0, 0};
    tbl[8]  = '{1, 1, 1, 0, 1, 0, 1, 1};
    tbl[9]  = '{1, 1, 1, 0, 0, 0, 1, 1};
    tbl[10] = '{1, 1, 1, 0, 0, 0, 1, 1};
    tbl[11] = '{1, 1, 1, 0, 0, 0, 1, 1};
    tbl[12] = '{1, 1, 1, 1, 0, 0, 1, 1};
    tbl[13] = '{0, 0, 0, 1, 0, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 1, 0, 0, 0, 0};

    do_reset();
    saved = '0;
    for (int i = 0; i < 15; i++) begin
      seq = seq + 1'b1;
      cycle(tbl[i].sv, tbl[i].vv, tbl[i].eop, tbl[i].ordy, seq, ~seq);
      chk1($sformatf("tbl%0d_sc_ready", i), obs_scr, tbl[i].scr);
      chk1($sformatf("tbl%0d_vc_ready", i), obs_vcr, tbl[i].vcr);
      chk1($sformatf("tbl%0d_out_valid", i), obs_ov, tbl[i].ov);
      if (tbl[i].ov) chk1($sformatf("tbl%0d_out_src", i), obs_src, tbl[i].src);
      if (i == 5)  chkw("conflicts_saturated", 64'(obs_conf), 64'd5);
      if (i == 7)  saved = obs_stall;
      if (i == 12) chkw("stalls_5_blocked", 64'(obs_stall - saved), 64'd3);
    end

    // Reset in the middle of a locked vector packet with beats buffered.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 64'hA1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 64'hA2);
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 64'hB1, 64'hC1);
    chk1("mid_reset_out_valid", obs_ov, 1'b0);
    chk1("mid_reset_tie_sc", obs_scr, 1'b1);
    chk1("mid_reset_tie_vc", obs_vcr, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Scalar-only stream.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      seq = seq + 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 1'b1, seq, '0);
      chk1("sc_stream_ready", obs_scr, 1'b1);
      if (i > 0) begin
        chk1("sc_stream_out_valid", obs_ov, 1'b1);
        chk1("sc_stream_out_src", obs_src, 1'b0);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // 4-beat vector packet with scalar pending.
    do_reset();
    popped.delete();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0, 64'hD1);
    for (int k = 2; k <= 4; k++) begin
      cycle(1'b1, 1'b1, 1'(k == 4), 1'b1, 64'hE1, 64'(k) + 64'hD0);
      chk1("lock_sc_ready", obs_scr, 1'b0);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 64'hE1, '0);
    chk1("post_eop_sc_ready", obs_scr, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    chkw("vec4_popped_count", 64'(popped.size()), 64'd5);
    for (int k = 0; k < 5 && k < popped.size(); k++)
      chk1($sformatf("vec4_order%0d", k), popped[k], 1'(k < 4));

    // 20-beat vector packet, scalar starves then gets the first arbitration point.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0, 64'h100);
    for (int k = 2; k <= 20; k++) begin
      cycle(1'b1, 1'b1, 1'(k == 20), 1'b1, 64'h200, 64'h100 + 64'(k));
      chk1("long_lock_sc_ready", obs_scr, 1'b0);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 64'h200, 64'h300);
    chk1("starve_grant_sc", obs_scr, 1'b1);
    chk1("starve_block_vc", obs_vcr, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 64'h201, 64'h300);
    chk1("after_starve_vc", obs_vcr, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
            rnd64(), rnd64());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
